// File: rtl/sample_loader.sv
// Collects four upstream samples into a 4-word store, optionally bit-reversing the
// write address, then holds the complete frame until downstream acknowledges it.
module sample_loader #(
    parameter int WORD_SIZE   = 16,
    parameter int BIT_REVERSE = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [WORD_SIZE-1:0] i_word,
    output logic                 o_ready,
    output logic                 o_wr_en,
    output logic [1:0]           o_address,
    output logic [WORD_SIZE-1:0] o_word,
    output logic                 o_frame_valid,
    input  logic                 i_frame_ack,
    output logic                 o_drop,
    output logic [7:0]           o_frame_cnt
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           n_q, n_d;
    logic                 wr_en_q, wr_en_d;
    logic [1:0]           address_q, address_d;
    logic [WORD_SIZE-1:0] word_q, word_d;
    logic                 drop_q, drop_d;
    logic [7:0]           frame_cnt_q, frame_cnt_d;

    logic                 ready;
    logic                 accept;
    logic [1:0]           n_rev;
    logic [1:0]           slot_addr;

    // Mirror the index bits so samples land in bit-reversed order.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rev
            assign n_rev[gi] = n_q[1-gi];
        end
    endgenerate

    assign slot_addr = (BIT_REVERSE != 0) ? n_rev : n_q;
    assign ready     = (state_q == FILL);
    assign accept    = i_valid & ready;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        wr_en_d     = accept;
        address_d   = address_q;
        word_d      = word_q;
        drop_d      = i_valid & ~ready;
        frame_cnt_d = frame_cnt_q;

        if (accept) begin
            n_d       = n_q + 2'd1;
            address_d = slot_addr;
            word_d    = i_word;
        end

        case (state_q)
            FILL: begin
                if (accept && (n_q == 2'd3)) begin
                    state_d = FLUSH;
                end
            end
            // Single cycle that carries the registered fourth write strobe.
            FLUSH: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (i_frame_ack) begin
                    state_d     = FILL;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= FILL;
            n_q         <= 2'd0;
            wr_en_q     <= 1'b0;
            address_q   <= 2'd0;
            word_q      <= '0;
            drop_q      <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            wr_en_q     <= wr_en_d;
            address_q   <= address_d;
            word_q      <= word_d;
            drop_q      <= drop_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_ready       = ready;
    assign o_wr_en       = wr_en_q;
    assign o_address     = address_q;
    assign o_word        = word_q;
    assign o_frame_valid = (state_q == HOLD);
    assign o_drop        = drop_q;
    assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_sample_loader.sv
// Directed bench: one bit-reversed and one natural-order loader share all inputs.
module tb_sample_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] word = 16'h0;
    logic        ack = 1'b0;

    logic        r_ready, r_wr_en, r_frame_valid, r_drop;
    logic [1:0]  r_address;
    logic [15:0] r_word;
    logic [7:0]  r_frame_cnt;
    logic        n_ready, n_wr_en, n_frame_valid, n_drop;
    logic [1:0]  n_address;
    logic [15:0] n_word;
    logic [7:0]  n_frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    sample_loader #(.WORD_SIZE(16), .BIT_REVERSE(1)) dut_rev (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_word(word),
        .o_ready(r_ready), .o_wr_en(r_wr_en), .o_address(r_address), .o_word(r_word),
        .o_frame_valid(r_frame_valid), .i_frame_ack(ack), .o_drop(r_drop),
        .o_frame_cnt(r_frame_cnt)
    );

    sample_loader #(.WORD_SIZE(16), .BIT_REVERSE(0)) dut_nat (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_word(word),
        .o_ready(n_ready), .o_wr_en(n_wr_en), .o_address(n_address), .o_word(n_word),
        .o_frame_valid(n_frame_valid), .i_frame_ack(ack), .o_drop(n_drop),
        .o_frame_cnt(n_frame_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = 1'b0;
        ack   = 1'b0;
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic fill_frame(input logic [15:0] base);
        for (int k = 0; k < 4; k++) begin
            valid = 1'b1;
            word  = base + 16'(k);
            tick();
        end
        valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({r_wr_en, r_address, r_word, r_frame_valid, r_drop, r_frame_cnt, r_ready} !== {1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_rev: wr=%b a=%0d w=%h fv=%b dr=%b cnt=%0d rdy=%b, required 0 0 0000 0 0 0 1",
                     r_wr_en, r_address, r_word, r_frame_valid, r_drop, r_frame_cnt, r_ready);
        end
        n_checks++;
        if ({n_wr_en, n_address, n_word, n_frame_valid, n_drop, n_frame_cnt, n_ready} !== {1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_nat: wr=%b a=%0d w=%h fv=%b dr=%b cnt=%0d rdy=%b, required 0 0 0000 0 0 0 1",
                     n_wr_en, n_address, n_word, n_frame_valid, n_drop, n_frame_cnt, n_ready);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_fill_and_ack();
        logic [1:0]  exp_r [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
        logic [15:0] data  [4] = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
        for (int k = 0; k < 4; k++) begin
            valid = 1'b1;
            word  = data[k];
            if (k == 2) ack = 1'b1;  // ack during FILL must be ignored
            tick();
            ack = 1'b0;
            n_checks++;
            if ({r_wr_en, r_address, r_word, r_frame_valid} !== {1'b1, exp_r[k], data[k], 1'b0}) begin
                n_fail++;
                $display("FAIL fill_rev[%0d]: wr=%b a=%0d w=%h fv=%b, required 1 %0d %h 0",
                         k, r_wr_en, r_address, r_word, r_frame_valid, exp_r[k], data[k]);
            end
            n_checks++;
            if ({n_wr_en, n_address, n_word, n_ready} !== {1'b1, 2'(k), data[k], (k != 3)}) begin
                n_fail++;
                $display("FAIL fill_nat[%0d]: wr=%b a=%0d w=%h rdy=%b, required 1 %0d %h %b",
                         k, n_wr_en, n_address, n_word, n_ready, k, data[k], (k != 3));
            end
        end
        valid = 1'b0;
        ack   = 1'b1;  // ack in FLUSH must be ignored
        tick();
        ack   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({r_frame_valid, r_ready, r_wr_en, r_address, r_word, r_frame_cnt} !== {1'b1, 1'b0, 1'b0, 2'd3, 16'h000D, 8'd0}) begin
                n_fail++;
                $display("FAIL hold[%0d]: fv=%b rdy=%b wr=%b a=%0d w=%h cnt=%0d, required 1 0 0 3 000d 0",
                         c, r_frame_valid, r_ready, r_wr_en, r_address, r_word, r_frame_cnt);
            end
            if (c < 4) tick();
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++;
        if ({n_frame_cnt, n_ready, n_frame_valid, r_frame_cnt} !== {8'd1, 1'b1, 1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL ack: cnt_nat=%0d rdy=%b fv=%b cnt_rev=%0d, required 1 1 0 1",
                     n_frame_cnt, n_ready, n_frame_valid, r_frame_cnt);
        end
    endtask

    task automatic test_drop_in_hold();
        fill_frame(16'h0100);
        tick();
        for (int c = 0; c < 3; c++) begin
            valid = 1'b1;
            word  = 16'hDEAD;
            tick();
            n_checks++;
            if ({r_drop, r_wr_en, r_frame_valid, n_drop} !== {1'b1, 1'b0, 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL drop[%0d]: drop=%b wr=%b fv=%b drop_nat=%b, required 1 0 1 1",
                         c, r_drop, r_wr_en, r_frame_valid, n_drop);
            end
        end
        valid = 1'b0;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++;
        if ({r_drop, r_frame_cnt} !== {1'b0, 8'd2}) begin
            n_fail++;
            $display("FAIL drop_end: drop=%b cnt=%0d, required 0 2", r_drop, r_frame_cnt);
        end
        valid = 1'b1;
        word  = 16'h0055;
        tick();
        valid = 1'b0;
        n_checks++;
        if ({r_wr_en, r_address, r_word, n_address} !== {1'b1, 2'd0, 16'h0055, 2'd0}) begin
            n_fail++;
            $display("FAIL resume: wr=%b a=%0d w=%h a_nat=%0d, required 1 0 0055 0",
                     r_wr_en, r_address, r_word, n_address);
        end
    endtask

    task automatic test_ack_and_valid();
        do_reset();
        fill_frame(16'h0200);
        tick();
        valid = 1'b1;
        ack   = 1'b1;
        word  = 16'h0077;
        tick();
        ack   = 1'b0;
        n_checks++;
        if ({r_drop, r_wr_en, r_frame_cnt, r_ready, r_frame_valid} !== {1'b1, 1'b0, 8'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL ack_valid: drop=%b wr=%b cnt=%0d rdy=%b fv=%b, required 1 0 1 1 0",
                     r_drop, r_wr_en, r_frame_cnt, r_ready, r_frame_valid);
        end
        word = 16'h0088;
        tick();
        valid = 1'b0;
        n_checks++;
        if ({r_wr_en, r_address, r_word, r_drop} !== {1'b1, 2'd0, 16'h0088, 1'b0}) begin
            n_fail++;
            $display("FAIL ack_valid_next: wr=%b a=%0d w=%h drop=%b, required 1 0 0088 0",
                     r_wr_en, r_address, r_word, r_drop);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [1:0] exp_r [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
        do_reset();
        valid = 1'b1;
        word  = 16'h0301;
        tick();
        word  = 16'h0302;
        tick();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({r_wr_en, r_address, r_word, r_frame_valid, r_drop, r_frame_cnt, r_ready} !== {1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid: wr=%b a=%0d w=%h fv=%b dr=%b cnt=%0d rdy=%b, required 0 0 0000 0 0 0 1",
                     r_wr_en, r_address, r_word, r_frame_valid, r_drop, r_frame_cnt, r_ready);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            word = 16'h0400 + 16'(k);
            tick();
            n_checks++;
            if ({r_wr_en, r_address, r_word} !== {1'b1, exp_r[k], 16'h0400 + 16'(k)}) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: wr=%b a=%0d w=%h, required 1 %0d %h",
                         k, r_wr_en, r_address, r_word, exp_r[k], 16'h0400 + 16'(k));
            end
        end
        valid = 1'b0;
        tick();
        n_checks++;
        if (r_frame_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_frame: fv=%b, required 1", r_frame_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({r_frame_valid, r_frame_cnt, r_ready} !== {1'b0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_hold: fv=%b cnt=%0d rdy=%b, required 0 0 1",
                     r_frame_valid, r_frame_cnt, r_ready);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_back_to_back_wrap();
        do_reset();
        for (int f = 0; f < 256; f++) begin
            fill_frame(16'(f));
            tick();
            ack = 1'b1;
            tick();
            ack = 1'b0;
            if (f == 254) begin
                n_checks++;
                if (r_frame_cnt !== 8'd255) begin
                    n_fail++;
                    $display("FAIL cnt_255: cnt=%0d, required 255", r_frame_cnt);
                end
            end
        end
        n_checks++;
        if ({r_frame_cnt, n_frame_cnt, r_ready} !== {8'd0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL cnt_wrap: cnt=%0d cnt_nat=%0d rdy=%b, required 0 0 1",
                     r_frame_cnt, n_frame_cnt, r_ready);
        end
    endtask

    initial begin
        test_reset();
        test_fill_and_ack();
        test_drop_in_hold();
        test_ack_and_valid();
        test_reset_mid_frame();
        test_back_to_back_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_loader.md
SAMPLE_LOADER -- requirements
Module: sample_loader

Interface
REQ-001 Parameter: WORD_SIZE, default 16, sample width in bits.
REQ-002 Parameter: BIT_REVERSE, default 1; 1 = bit-reversed write order, 0 = natural order.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset; asynchronous, active-high.
REQ-005 i_valid  input  1  upstream sample present on i_word.
REQ-006 i_word  input  WORD_SIZE  upstream sample.
REQ-007 o_ready  output  1  block accepts a sample this cycle.
REQ-008 o_wr_en  output  1  write strobe to the 4-word sample store.
REQ-009 o_address  output  2  store address for o_word.
REQ-010 o_word  output  WORD_SIZE  data written to the store.
REQ-011 o_frame_valid  output  1  all 4 store words hold one complete frame.
REQ-012 i_frame_ack  input  1  downstream has consumed the frame.
REQ-013 o_drop  output  1  one-cycle pulse: sample offered while not ready.
REQ-014 o_frame_cnt  output  8  count of acknowledged frames.

Function
REQ-015 States FILL, FLUSH, HOLD; 2-bit sample index n.
REQ-016 o_ready is decoded from state: 1 in FILL only, 0 in FLUSH and HOLD.
REQ-017 Accept = i_valid & o_ready; on accept, n increments modulo 4.
REQ-018 The cycle after an accept: o_wr_en=1, o_word=accepted sample, o_address={n[0],n[1]} if BIT_REVERSE=1, else n (n = index before increment).
REQ-019 In any cycle with no accept in the previous cycle, o_wr_en=0; o_address and o_word hold their last values.
REQ-020 Accept with n=3: FILL->FLUSH; n wraps to 0.
REQ-021 FLUSH: one cycle only, carries the 4th write strobe; FLUSH->HOLD unconditionally.
REQ-022 o_frame_valid=1 exactly while in HOLD, i.e. it rises the cycle after the 4th write strobe.
REQ-023 HOLD with i_frame_ack=1: HOLD->FILL; o_frame_cnt increments, wrapping 255->0.
REQ-024 i_frame_ack outside HOLD is ignored; no state change and no count change.
REQ-025 i_valid=1 while o_ready=0 drives o_drop=1 on the next cycle; the sample is discarded and n is unchanged.
REQ-026 HOLD with i_frame_ack=1 and i_valid=1 in the same cycle: the sample is dropped (o_drop pulses); o_ready returns to 1 the following cycle.
REQ-027 Back-to-back frames: a new frame's first accept is possible the first cycle after the HOLD->FILL transition.
REQ-028 o_address is at most 3; o_frame_cnt is an unsigned 8-bit value.

Reset
REQ-029 i_rst=1 asynchronously forces state=FILL and n=0.
REQ-030 While i_rst=1, o_wr_en, o_address, o_word, o_frame_valid, o_drop and o_frame_cnt are all 0; o_ready is 1.
REQ-031 Reset mid-frame discards the partial frame; the first accept after reset is written to address 0.
REQ-032 Reset in HOLD clears o_frame_valid immediately, with no count increment.

Verification
REQ-033 BIT_REVERSE=1, samples 0x000A, 0x000B, 0x000C, 0x000D on consecutive cycles -> strobes to addresses 0, 2, 1, 3 with those data; o_frame_valid rises 2 cycles after the 4th accept; o_ready=0 from the cycle after the 4th accept.
REQ-034 BIT_REVERSE=0, same stimulus -> addresses 0, 1, 2, 3; ack after 5 HOLD cycles -> o_frame_cnt=1, o_ready=1 the next cycle.
REQ-035 i_valid held high through HOLD for 3 cycles -> 3 o_drop pulses, no o_wr_en, n=0 on resume.
REQ-036 Same-cycle ack and valid in HOLD -> o_drop=1, o_frame_cnt increments, and the next sample goes to address 0.
REQ-037 2 samples accepted, then i_rst pulsed -> all outputs 0 and o_ready=1; next 4 samples form a full frame starting at address 0.
REQ-038 256 complete frames acknowledged -> o_frame_cnt wraps to 0.
